// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the instruction memory
// combinationally and captures the returned word into the IF/ID register.
// Optional macro IF_PERF_CNT_EN adds FetchCount/BubbleCount outputs.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 128
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectTarget,
  output logic [31:0] IMemAddress,
  input  logic [31:0] IMemInstruction,
  output logic [31:0] IFID_Instruction,
  output logic [31:0] IFID_PCPlus4,
  output logic        IFID_Valid,
`ifdef IF_PERF_CNT_EN
  output logic [31:0] FetchCount,
  output logic [31:0] BubbleCount,
`endif
  output logic        Halted
);

  // First byte address past the end of the program store.
  localparam logic [31:0] LIMIT = 32'(IMEM_WORDS) << 2;

  logic [31:0] r_pc, w_pc_d;
  logic [31:0] r_instr, w_instr_d;
  logic [31:0] r_pc4, w_pc4_d;
  logic        r_valid, w_valid_d;
  logic        r_halted, w_halted_d;
  logic        w_load_fetch;
  logic        w_load_bubble;
  logic [31:0] w_target;
  logic [31:0] w_pc_plus4;

  assign w_target   = {RedirectTarget[31:2], 2'b00};
  assign w_pc_plus4 = r_pc + 32'd4;

  // Next-state selection, priority Redirect > Halted > Stall > normal fetch.
  always_comb begin
    w_pc_d        = r_pc;
    w_instr_d     = r_instr;
    w_pc4_d       = r_pc4;
    w_valid_d     = r_valid;
    w_halted_d    = r_halted;
    w_load_fetch  = 1'b0;
    w_load_bubble = 1'b0;
    if (Redirect) begin
      w_pc_d        = w_target;
      w_halted_d    = (w_target >= LIMIT);
      w_load_bubble = 1'b1;
    end else if (r_halted) begin
      w_load_bubble = 1'b1;
    end else if (Stall) begin
      // Everything holds.
    end else if (r_pc < LIMIT) begin
      w_pc_d       = w_pc_plus4;
      w_instr_d    = IMemInstruction;
      w_pc4_d      = w_pc_plus4;
      w_valid_d    = 1'b1;
      w_load_fetch = 1'b1;
    end else begin
      w_halted_d    = 1'b1;
      w_load_bubble = 1'b1;
    end
    if (w_load_bubble) begin
      w_instr_d = 32'd0;
      w_pc4_d   = 32'd0;
      w_valid_d = 1'b0;
    end
  end

  // PC, IF/ID register and sticky halt flag.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_pc     <= RESET_PC;
      r_instr  <= 32'd0;
      r_pc4    <= 32'd0;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_pc     <= w_pc_d;
      r_instr  <= w_instr_d;
      r_pc4    <= w_pc4_d;
      r_valid  <= w_valid_d;
      r_halted <= w_halted_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_bubble_cnt;

  // Performance counters; stall cycles load neither.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_fetch_cnt  <= 32'd0;
      r_bubble_cnt <= 32'd0;
    end else begin
      if (w_load_fetch)  r_fetch_cnt  <= r_fetch_cnt + 32'd1;
      if (w_load_bubble) r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign FetchCount  = r_fetch_cnt;
  assign BubbleCount = r_bubble_cnt;
`endif

  assign IMemAddress      = r_pc;
  assign IFID_Instruction = r_instr;
  assign IFID_PCPlus4     = r_pc4;
  assign IFID_Valid       = r_valid;
  assign Halted           = r_halted;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios with literal
// expectations, then randomized stall/redirect traffic against a model.
module tb_if_fetch_stage;

  localparam int unsigned WORDS = 128;
  localparam int unsigned LIM   = WORDS * 4;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Stall;
  logic        Redirect;
  logic [31:0] RedirectTarget;
  logic [31:0] IMemAddress;
  logic [31:0] IMemInstruction;
  logic [31:0] IFID_Instruction;
  logic [31:0] IFID_PCPlus4;
  logic        IFID_Valid;
  logic        Halted;
`ifdef IF_PERF_CNT_EN
  logic [31:0] FetchCount;
  logic [31:0] BubbleCount;
`endif

  logic [31:0] mem [WORDS];

  int vectors    = 0;
  int miscompares = 0;
  bit chk_en     = 1'b0;

  // Model state
  longint unsigned m_pc;
  logic [31:0]     m_instr;
  logic [31:0]     m_pc4;
  bit              m_valid;
  bit              m_halted;
  longint unsigned m_fetch;
  longint unsigned m_bubble;

  always #5 Clk = ~Clk;

  assign IMemInstruction = (IMemAddress < LIM) ? mem[IMemAddress[8:2]] : 32'hDEAD_BEEF;

  if_fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_WORDS(WORDS)
  ) dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .Stall           (Stall),
    .Redirect        (Redirect),
    .RedirectTarget  (RedirectTarget),
    .IMemAddress     (IMemAddress),
    .IMemInstruction (IMemInstruction),
    .IFID_Instruction(IFID_Instruction),
    .IFID_PCPlus4    (IFID_PCPlus4),
    .IFID_Valid      (IFID_Valid),
`ifdef IF_PERF_CNT_EN
    .FetchCount      (FetchCount),
    .BubbleCount     (BubbleCount),
`endif
    .Halted          (Halted)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: applies the priority rules to its own PC each edge.
  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_halted = 0;
      m_fetch = 0; m_bubble = 0;
    end else if (Redirect) begin
      m_pc = RedirectTarget - (RedirectTarget % 4);
      m_halted = (m_pc >= LIM);
      m_instr = 0; m_pc4 = 0; m_valid = 0; m_bubble++;
    end else if (m_halted) begin
      m_instr = 0; m_pc4 = 0; m_valid = 0; m_bubble++;
    end else if (Stall) begin
      // frozen
    end else if (m_pc < LIM) begin
      m_instr = mem[m_pc / 4];
      m_pc    = (m_pc + 4) % (64'd1 << 32);
      m_pc4   = 32'(m_pc);
      m_valid = 1;
      m_fetch++;
    end else begin
      m_halted = 1;
      m_instr = 0; m_pc4 = 0; m_valid = 0; m_bubble++;
    end
  end

  // Compare process, away from the rising edge.
  always @(negedge Clk) begin
    if (chk_en) begin
      chk("IMemAddress", IMemAddress, 32'(m_pc));
      chk("IFID_Instruction", IFID_Instruction, m_instr);
      chk("IFID_PCPlus4", IFID_PCPlus4, m_pc4);
      chk("IFID_Valid", {31'd0, IFID_Valid}, {31'd0, m_valid});
      chk("Halted", {31'd0, Halted}, {31'd0, m_halted});
`ifdef IF_PERF_CNT_EN
      chk("FetchCount", FetchCount, 32'(m_fetch));
      chk("BubbleCount", BubbleCount, 32'(m_bubble));
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic drive(input bit s, input bit r, input logic [31:0] t);
    Stall = s; Redirect = r; RedirectTarget = t;
  endtask

  task automatic chk_ifid(input string name, input logic [31:0] addr,
                          input logic [31:0] ins, input logic [31:0] pc4, input bit v);
    chk({name, "_addr"}, IMemAddress, addr);
    chk({name, "_instr"}, IFID_Instruction, ins);
    chk({name, "_pc4"}, IFID_PCPlus4, pc4);
    chk({name, "_valid"}, {31'd0, IFID_Valid}, {31'd0, v});
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) mem[i] = 32'(i * 3);
    Reset = 1'b1;
    drive(0, 0, 0);
    step(2);
    chk_ifid("reset", 32'h0, 32'h0, 32'h0, 0);
    chk("reset_halted", {31'd0, Halted}, 32'd0);
    Reset = 1'b0;
    chk_en = 1'b1;

    // Sequential fetch
    step(1); chk_ifid("seq1", 32'd4, 32'd0, 32'd4, 1);
    step(1); chk_ifid("seq2", 32'd8, 32'd3, 32'd8, 1);
    // Stall at PC=8
    drive(1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1); chk_ifid("stall", 32'd8, 32'd3, 32'd8, 1);
    end
    drive(0, 0, 0);
    step(1); chk_ifid("unstall", 32'd12, 32'd6, 32'd12, 1);
    step(1); chk("pc16", IMemAddress, 32'd16);
    // Redirect with stall, misaligned target
    drive(1, 1, 32'h0000_0023);
    step(1); chk_ifid("redir", 32'h20, 32'd0, 32'd0, 0);
    drive(0, 0, 0);
    step(1); chk_ifid("post_redir", 32'd36, 32'd24, 32'd36, 1);

    // Last word then halt
    drive(0, 1, 32'd508);
    step(1); chk_ifid("to508", 32'd508, 32'd0, 32'd0, 0);
    drive(0, 0, 0);
    step(1); chk_ifid("last", 32'd512, 32'd381, 32'd512, 1);
    chk("last_halted", {31'd0, Halted}, 32'd0);
    step(1); chk_ifid("halt", 32'd512, 32'd0, 32'd0, 0);
    chk("halt_set", {31'd0, Halted}, 32'd1);
    drive(1, 0, 0);
    step(2); chk_ifid("halt_hold", 32'd512, 32'd0, 32'd0, 0);
    chk("halt_sticky", {31'd0, Halted}, 32'd1);
    drive(0, 1, 32'd0);
    step(1); chk("halt_clear", {31'd0, Halted}, 32'd0);
    drive(0, 0, 0);
    step(1); chk_ifid("resume", 32'd4, 32'd0, 32'd4, 1);

    // Asynchronous reset between edges
    step(3);
    #2 Reset = 1'b1;
    #1 chk_ifid("async_rst", 32'd0, 32'd0, 32'd0, 0);
    chk("async_rst_halted", {31'd0, Halted}, 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    step(1); chk_ifid("restart", 32'd4, 32'd0, 32'd4, 1);

`ifdef IF_PERF_CNT_EN
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    step(5);
    drive(1, 0, 0); step(2);
    drive(0, 1, 32'd0); step(1);
    drive(0, 0, 0);
    chk("perf_fetch", FetchCount, 32'd5);
    chk("perf_bubble", BubbleCount, 32'd1);
`endif

    // Randomized traffic
    for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
    for (int c = 0; c < 3000; c++) begin
      Stall    = ($urandom_range(0, 3) == 0);
      Redirect = ($urandom_range(0, 19) == 0);
      RedirectTarget = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 530));
      if ($urandom_range(0, 499) == 0) begin
        #2 Reset = 1'b1;
        #1 Reset = 1'b0;
      end
      @(negedge Clk);
    end
    drive(0, 0, 0);
    step(1);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
